// File: rtl/board_io_ctrl.sv
// Board I/O glue: button debounce, stretched system reset, USB pad muxing with RX turnaround, LEDs.
// Optional heartbeat LED on led[N_LED-1] when BOARD_IO_HEARTBEAT_EN is defined.
module board_io_ctrl #(
  parameter int N_BTN             = 7,
  parameter int N_LED             = 8,
  parameter int DEBOUNCE_CYCLES   = 48000,
  parameter int RST_BTN           = 0,
  parameter int RESET_HOLD_CYCLES = 4800,
  parameter int TURNAROUND_CYCLES = 2
) (
  input  logic             clk_48mhz,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_db,
  output logic             sys_reset,
  output logic             wifi_gpio0,
  input  logic             usb_tx_en,
  input  logic             usb_p_tx,
  input  logic             usb_n_tx,
  input  logic             usb_dp_i,
  input  logic             usb_dn_i,
  output logic             usb_dp_o,
  output logic             usb_dn_o,
  output logic             usb_oe,
  output logic             usb_p_rx,
  output logic             usb_n_rx,
  input  logic             pin_led,
  input  logic             boot,
  output logic [N_LED-1:0] led
);

  localparam int DB_W   = (DEBOUNCE_CYCLES   > 0) ? $clog2(DEBOUNCE_CYCLES + 1)   : 1;
  localparam int HOLD_W = (RESET_HOLD_CYCLES > 0) ? $clog2(RESET_HOLD_CYCLES + 1) : 1;
  localparam int TA_W   = (TURNAROUND_CYCLES > 0) ? $clog2(TURNAROUND_CYCLES + 1) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((RESET_HOLD_CYCLES > 0) ? RESET_HOLD_CYCLES - 1 : 0);
  localparam logic [TA_W-1:0]   TA_LOAD   = TA_W'(TURNAROUND_CYCLES);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    RST_ACTIVE = 2'd1,
    RST_HOLD   = 2'd2
  } rst_state_e;

  logic [N_BTN-1:0]            sync1_r;
  logic [N_BTN-1:0]            sync2_r;
  logic [N_BTN-1:0]            btn_db_r;
  logic [N_BTN-1:0]            btn_db_nxt_s;
  logic [N_BTN-1:0][DB_W-1:0]  db_cnt_r;
  logic [N_BTN-1:0][DB_W-1:0]  db_cnt_nxt_s;

  rst_state_e                  state_r;
  rst_state_e                  state_nxt_s;
  logic [HOLD_W-1:0]           hold_cnt_r;
  logic [HOLD_W-1:0]           hold_cnt_nxt_s;
  logic                        rst_btn_s;
  logic                        sys_reset_r;

  logic [TA_W-1:0]             ta_cnt_r;
  logic [TA_W-1:0]             ta_cnt_nxt_s;
  logic                        rx_force_s;
  logic                        hb_led_s;

  // Two-flop synchronizer for the raw buttons; released level is 1.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= '1;
      sync2_r <= '1;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Per-button stability counter; any agreement with the current debounced level restarts it.
  always_comb begin
    btn_db_nxt_s = btn_db_r;
    db_cnt_nxt_s = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync2_r[i] == btn_db_r[i]) begin
        db_cnt_nxt_s[i] = '0;
      end else if (db_cnt_r[i] == DB_LAST) begin
        btn_db_nxt_s[i] = sync2_r[i];
        db_cnt_nxt_s[i] = '0;
      end else begin
        db_cnt_nxt_s[i] = db_cnt_r[i] + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      btn_db_r <= '1;
      db_cnt_r <= '0;
    end else begin
      btn_db_r <= btn_db_nxt_s;
      db_cnt_r <= db_cnt_nxt_s;
    end
  end

  // The FSM looks at the debounced value being loaded this cycle, so sys_reset
  // moves on the same edge as btn_db rather than one cycle later.
  assign rst_btn_s = btn_db_nxt_s[RST_BTN];

  // Reset FSM next-state and hold counter.
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = '0;
    case (state_r)
      RUN: begin
        if (!rst_btn_s) begin
          state_nxt_s = RST_ACTIVE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      RST_ACTIVE: begin
        if (rst_btn_s) begin
          state_nxt_s = RST_HOLD;
        end else begin
          state_nxt_s = RST_ACTIVE;
        end
      end
      RST_HOLD: begin
        if (!rst_btn_s) begin
          state_nxt_s = RST_ACTIVE;
        end else if (hold_cnt_r >= HOLD_LAST) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s    = RST_HOLD;
          hold_cnt_nxt_s = hold_cnt_r + 1'b1;
        end
      end
      default: begin
        state_nxt_s = RST_ACTIVE;
      end
    endcase
  end

  // Reset FSM state and registered sys_reset.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= RST_ACTIVE;
      hold_cnt_r  <= '0;
      sys_reset_r <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      hold_cnt_r  <= hold_cnt_nxt_s;
      sys_reset_r <= (state_nxt_s != RUN);
    end
  end

  // Turnaround counter: held at full load while transmitting, drains after tx_en drops.
  always_comb begin
    ta_cnt_nxt_s = ta_cnt_r;
    if (usb_tx_en) begin
      ta_cnt_nxt_s = TA_LOAD;
    end else if (ta_cnt_r != '0) begin
      ta_cnt_nxt_s = ta_cnt_r - 1'b1;
    end else begin
      ta_cnt_nxt_s = '0;
    end
  end

  // Turnaround counter register.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      ta_cnt_r <= '0;
    end else begin
      ta_cnt_r <= ta_cnt_nxt_s;
    end
  end

  assign rx_force_s = usb_tx_en | (ta_cnt_r != '0);

  // RX sees idle J while our own transmission and its echo are on the bus.
  always_comb begin
    usb_oe   = usb_tx_en;
    usb_dp_o = usb_p_tx;
    usb_dn_o = usb_n_tx;
    if (rx_force_s) begin
      usb_p_rx = 1'b1;
      usb_n_rx = 1'b0;
    end else begin
      usb_p_rx = usb_dp_i;
      usb_n_rx = usb_dn_i;
    end
  end

`ifdef BOARD_IO_HEARTBEAT_EN
  logic [23:0] hb_cnt_r;

  // Heartbeat counter restarts from zero each time the core comes out of reset.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      hb_cnt_r <= 24'd0;
    end else if (sys_reset_r) begin
      hb_cnt_r <= 24'd0;
    end else begin
      hb_cnt_r <= hb_cnt_r + 24'd1;
    end
  end

  assign hb_led_s = hb_cnt_r[23] & ~sys_reset_r;
`else
  assign hb_led_s = 1'b0;
`endif

  // LED map; fixed functions take priority over the heartbeat bit.
  always_comb begin
    led = '0;
    for (int i = 0; i < N_LED; i++) begin
      if (i == 0) begin
        led[i] = pin_led;
      end else if (i == 1) begin
        led[i] = sys_reset_r;
      end else if (i == 5) begin
        led[i] = boot;
      end else if (i == N_LED - 1) begin
        led[i] = hb_led_s;
      end else begin
        led[i] = 1'b0;
      end
    end
  end

  assign btn_db     = btn_db_r;
  assign sys_reset  = sys_reset_r;
  assign wifi_gpio0 = btn_db_r[RST_BTN];

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl: directed scenarios plus random stimulus
// compared every cycle against a history-based reference model.
module tb_board_io_ctrl;

  localparam int NB = 7;
  localparam int NL = 8;
  localparam int D  = 8;
  localparam int H  = 16;
  localparam int T  = 2;

  logic          clk_48mhz = 1'b0;
  logic          reset_n   = 1'b0;
  logic [NB-1:0] btn       = '1;
  logic [NB-1:0] btn_db;
  logic          sys_reset, wifi_gpio0;
  logic          usb_tx_en = 1'b0, usb_p_tx = 1'b0, usb_n_tx = 1'b0;
  logic          usb_dp_i = 1'b0, usb_dn_i = 1'b1;
  logic          usb_dp_o, usb_dn_o, usb_oe, usb_p_rx, usb_n_rx;
  logic          pin_led = 1'b0, boot = 1'b0;
  logic [NL-1:0] led;

  board_io_ctrl #(
    .N_BTN(NB), .N_LED(NL), .DEBOUNCE_CYCLES(D), .RST_BTN(0),
    .RESET_HOLD_CYCLES(H), .TURNAROUND_CYCLES(T)
  ) dut (
    .clk_48mhz(clk_48mhz), .reset_n(reset_n), .btn(btn), .btn_db(btn_db),
    .sys_reset(sys_reset), .wifi_gpio0(wifi_gpio0), .usb_tx_en(usb_tx_en),
    .usb_p_tx(usb_p_tx), .usb_n_tx(usb_n_tx), .usb_dp_i(usb_dp_i), .usb_dn_i(usb_dn_i),
    .usb_dp_o(usb_dp_o), .usb_dn_o(usb_dn_o), .usb_oe(usb_oe),
    .usb_p_rx(usb_p_rx), .usb_n_rx(usb_n_rx), .pin_led(pin_led), .boot(boot), .led(led)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: raw button samples per edge, debounced levels, age of the
  // reset button's last release, and recent tx_en samples.
  logic [NB-1:0] hist[$];
  logic [NB-1:0] mdb;
  int            age;
  logic          taq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_sys();
    return (mdb[0] == 1'b0) || (age < H);
  endfunction

  task automatic model_reset();
    hist = {};
    repeat (D + 1) hist.push_back('1);
    mdb = '1;
    age = -1;
    taq = {};
    repeat (T) taq.push_back(1'b0);
  endtask

  // A bit flips once its last D synchronized samples all disagree with it;
  // synchronized sample at edge k is the raw sample from edge k-2.
  task automatic model_edge();
    logic [NB-1:0] nd;
    nd = mdb;
    for (int b = 0; b < NB; b++) begin
      bit all_diff;
      all_diff = 1'b1;
      for (int i = 0; i < D; i++) begin
        if (hist[i][b] == mdb[b]) all_diff = 1'b0;
      end
      if (all_diff) nd[b] = ~mdb[b];
    end
    hist.push_back(btn);
    void'(hist.pop_front());
    if (!mdb[0] && nd[0]) age = 0;
    else if (age < 100000) age++;
    mdb = nd;
    taq.push_back(usb_tx_en);
    void'(taq.pop_front());
  endtask

  task automatic check_comb();
    logic          frc;
    logic [NL-1:0] le;
    frc = usb_tx_en;
    foreach (taq[i]) if (taq[i]) frc = 1'b1;
    chk("usb_p_rx", usb_p_rx, frc ? 1'b1 : usb_dp_i);
    chk("usb_n_rx", usb_n_rx, frc ? 1'b0 : usb_dn_i);
    chk("usb_oe", usb_oe, usb_tx_en);
    chk("usb_dp_o", usb_dp_o, usb_p_tx);
    chk("usb_dn_o", usb_dn_o, usb_n_tx);
    le    = '0;
    le[0] = pin_led;
    le[1] = model_sys();
    le[5] = boot;
    chk("led", led, le);
  endtask

  task automatic check_reg();
    chk("btn_db", btn_db, mdb);
    chk("sys_reset", sys_reset, model_sys());
    chk("wifi_gpio0", wifi_gpio0, mdb[0]);
  endtask

  // One clock: inputs already driven at posedge+1; ends at the next posedge+1.
  task automatic cycle();
    #2;
    check_comb();
    @(posedge clk_48mhz);
    model_edge();
    #1;
    check_reg();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk_48mhz);
    #1;
    chk("rst_btn_db", btn_db, 7'h7f);
    chk("rst_sys_reset", sys_reset, 1'b1);
    chk("rst_wifi", wifi_gpio0, 1'b1);
    chk("rst_led1", led[1], 1'b1);
    reset_n = 1'b1;

    // Power-on stretch: 16 cycles of sys_reset after release.
    run(16);
    chk("por_hold_end", sys_reset, 1'b1);
    run(1);
    chk("por_run", sys_reset, 1'b0);
    run(4);

    // Clean press: btn_db follows exactly 10 cycles later.
    btn[3] = 1'b0;
    run(9);
    chk("db_pre", btn_db[3], 1'b1);
    run(1);
    chk("db_edge", btn_db[3], 1'b0);
    run(10);
    btn[3] = 1'b1;
    run(15);

    // Short glitch is filtered.
    btn[3] = 1'b0;
    run(5);
    btn[3] = 1'b1;
    run(15);
    chk("glitch", btn_db[3], 1'b1);

    // Reset button press/release: rise 10 after press, fall 26 after release.
    btn[0] = 1'b0;
    run(9);
    chk("rb_pre", sys_reset, 1'b0);
    run(1);
    chk("rb_rise", sys_reset, 1'b1);
    run(2);
    btn[0] = 1'b1;
    run(25);
    chk("rb_hold", sys_reset, 1'b1);
    run(1);
    chk("rb_fall", sys_reset, 1'b0);
    run(4);

    // Re-press 6 cycles into hold.
    btn[0] = 1'b0;
    run(12);
    btn[0] = 1'b1;
    run(16);
    btn[0] = 1'b0;
    run(12);
    btn[0] = 1'b1;
    run(30);

    // USB turnaround, then a re-pulse on turnaround cycle 1.
    usb_dp_i = 1'b0;
    usb_dn_i = 1'b1;
    usb_tx_en = 1'b1; usb_p_tx = 1'b1;
    run(5);
    usb_tx_en = 1'b0; usb_p_tx = 1'b0;
    run(2);
    chk("ta_end_p", usb_p_rx, 1'b0);
    chk("ta_end_n", usb_n_rx, 1'b1);
    run(3);
    usb_tx_en = 1'b1;
    run(5);
    usb_tx_en = 1'b0;
    run(1);
    usb_tx_en = 1'b1;
    run(1);
    usb_tx_en = 1'b0;
    run(5);

    // Random stimulus.
    for (int c = 0; c < 800; c++) begin
      for (int b = 1; b < NB; b++) begin
        if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
      end
      if ($urandom_range(0, 39) == 0) btn[0] = ~btn[0];
      if ($urandom_range(0, 3) == 0) usb_tx_en = ~usb_tx_en;
      usb_p_tx = 1'($urandom);
      usb_n_tx = 1'($urandom);
      usb_dp_i = 1'($urandom);
      usb_dn_i = 1'($urandom);
      pin_led  = 1'($urandom);
      boot     = 1'($urandom);
      cycle();
    end

    // Asynchronous reset mid-hold and mid-turnaround.
    btn = '1;
    usb_tx_en = 1'b0;
    run(40);
    btn[2] = 1'b0;
    btn[0] = 1'b0;
    run(12);
    btn[0] = 1'b1;
    run(13);
    usb_tx_en = 1'b1;
    run(2);
    usb_tx_en = 1'b0;
    usb_dp_i = 1'b0;
    usb_dn_i = 1'b1;
    run(1);
    chk("pre_abort_sys", sys_reset, 1'b1);
    chk("pre_abort_db2", btn_db[2], 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("abort_db", btn_db, 7'h7f);
    chk("abort_sys", sys_reset, 1'b1);
    chk("abort_p_rx", usb_p_rx, 1'b0);
    chk("abort_n_rx", usb_n_rx, 1'b1);
    @(posedge clk_48mhz);
    @(posedge clk_48mhz);
    #1;
    reset_n = 1'b1;
    btn = '1;
    run(30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
